// File: rtl/rom_dl_pkg.sv
// Shared types for the ROM download controller: FSM states,
// queued SDRAM write entry and byte-to-entry helpers.
package rom_dl_pkg;

  localparam int RAM_AW_DEF = 22;
  localparam int ENT_AW = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DRAIN,
    S_HOLD,
    S_RUN
  } state_t;

  typedef struct packed {
    logic [ENT_AW-1:0] addr;
    logic [15:0]       din;
    logic [1:0]        ds;
  } q_entry_t;

  function automatic q_entry_t mk_single(
    input logic [24:0] a,
    input logic [7:0]  b
  );
    q_entry_t e;
    e.addr = a[24:1];
    e.din  = {b, b};
    e.ds   = a[0] ? 2'b10 : 2'b01;
    return e;
  endfunction

  function automatic q_entry_t mk_pair(
    input logic [24:0] a,
    input logic [7:0]  hi,
    input logic [7:0]  lo
  );
    q_entry_t e;
    e.addr = a[24:1];
    e.din  = {hi, lo};
    e.ds   = 2'b11;
    return e;
  endfunction

endpackage

// File: rtl/rom_dl_fifo.sv
// Pending-write queue; a full queue still accepts a push when a
// pop happens in the same cycle.
module rom_dl_fifo
  import rom_dl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_sys,
  input  logic     rst_n,
  input  logic     push,
  input  q_entry_t din,
  input  logic     pop,
  output q_entry_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  q_entry_t mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_pop;
  logic          do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/rom_dl_ctrl.sv
// ROM download to SDRAM with byte packing, write queue and core reset.
// Optional checksum logic: define ROM_DL_CHECKSUM_EN.
module rom_dl_ctrl
  import rom_dl_pkg::*;
#(
  parameter logic [7:0]  ROM_INDEX   = 8'd0,
  parameter int          RAM_AW      = RAM_AW_DEF,
  parameter logic [24:0] ROM_LIMIT   = 25'h20000,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          HOLD_CYCLES = 16
) (
  input  logic              clk_sys,
  input  logic              init_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              soft_reset,
  output logic              ram_req,
  input  logic              ram_ack,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       ram_din,
  output logic [1:0]        ram_ds,
  output logic              ram_we,
  output logic              rom_loaded,
  output logic              core_reset,
  output logic              overflow,
  output logic [15:0]       checksum
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  logic [1:0]  rst_sync;
  logic        rst_s;
  state_t      st;
  logic        wr_q;
  logic        soft_q;
  logic        pack_v;
  logic [24:0] pa;
  logic [7:0]  pb;
  logic [7:0]  hc;

  logic        dl_start;
  logic        accept;
  logic        pair_ok;
  logic        acc_pair;
  logic        acc_held;
  logic        acc_odd;
  logic        fl_held;
  logic        push;
  q_entry_t    push_e;
  q_entry_t    head;
  logic        q_full;
  logic        q_empty;
  logic        hs_idle;
  logic        issue;

  // Release is resynchronised; assertion stays asynchronous.
  always_ff @(posedge clk_sys or negedge init_n) begin
    if (!init_n) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_s = rst_sync[1];

  assign dl_start = ioctl_download & (ioctl_index == ROM_INDEX);
  assign accept   = (st == S_LOAD) & ioctl_download
                  & ioctl_wr & ~wr_q & (ioctl_addr < ROM_LIMIT);
  assign pair_ok  = pack_v & ~pa[0] & ioctl_addr[0]
                  & (pa[24:1] == ioctl_addr[24:1]);
  assign hs_idle  = (ram_req == ram_ack);
  assign issue    = hs_idle & ~q_empty;

  always_comb begin
    acc_pair = accept & pair_ok;
    acc_held = accept & ~pair_ok & pack_v;
    acc_odd  = accept & ~pack_v & ioctl_addr[0];
    fl_held  = (st == S_FLUSH) & pack_v;
    push     = 1'b0;
    push_e   = '0;
    unique case (1'b1)
      acc_pair: begin
        push   = 1'b1;
        push_e = mk_pair(ioctl_addr, ioctl_dout, pb);
      end
      acc_held, fl_held: begin
        push   = 1'b1;
        push_e = mk_single(pa, pb);
      end
      acc_odd: begin
        push   = 1'b1;
        push_e = mk_single(ioctl_addr, ioctl_dout);
      end
      default: ;
    endcase
  end

  rom_dl_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_sys(clk_sys),
    .rst_n  (rst_s),
    .push   (push),
    .din    (push_e),
    .pop    (issue),
    .dout   (head),
    .full   (q_full),
    .empty  (q_empty)
  );

  always_ff @(posedge clk_sys or negedge rst_s) begin
    if (!rst_s) begin
      st         <= S_IDLE;
      wr_q       <= 1'b0;
      soft_q     <= 1'b0;
      pack_v     <= 1'b0;
      pa         <= '0;
      pb         <= '0;
      hc         <= '0;
      ram_req    <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      ram_ds     <= '0;
      ram_we     <= 1'b1;
      rom_loaded <= 1'b0;
      core_reset <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      wr_q   <= ioctl_wr;
      soft_q <= soft_reset;
      if (push & q_full & ~issue) overflow <= 1'b1;
      if (issue) begin
        ram_req  <= ~ram_req;
        ram_addr <= head.addr[RAM_AW-1:0];
        ram_din  <= head.din;
        ram_ds   <= head.ds;
      end
      // An odd byte that cannot pair waits in the pack register too.
      if (acc_pair) begin
        pack_v <= 1'b0;
      end else if (accept & (pack_v | ~ioctl_addr[0])) begin
        pack_v <= 1'b1;
        pa     <= ioctl_addr;
        pb     <= ioctl_dout;
      end else if (st == S_FLUSH) begin
        pack_v <= 1'b0;
      end
      unique case (st)
        S_IDLE: begin
          if (dl_start) st <= S_LOAD;
        end
        S_LOAD: begin
          if (!ioctl_download) st <= S_FLUSH;
        end
        S_FLUSH: begin
          st <= S_DRAIN;
        end
        S_DRAIN: begin
          if (dl_start) begin
            st <= S_LOAD;
          end else if (q_empty && hs_idle) begin
            st <= S_HOLD;
            hc <= '0;
          end
        end
        S_HOLD: begin
          if (dl_start) begin
            st <= S_LOAD;
          end else if (hc == HOLD_LAST) begin
            st         <= S_RUN;
            rom_loaded <= 1'b1;
            core_reset <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '1;
          end else begin
            hc <= hc + 1'b1;
          end
        end
        S_RUN: begin
          if (dl_start) begin
            st         <= S_LOAD;
            core_reset <= 1'b1;
            ram_we     <= 1'b1;
            ram_addr   <= '0;
          end else begin
            core_reset <= soft_reset & ~soft_q;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

`ifdef ROM_DL_CHECKSUM_EN
  always_ff @(posedge clk_sys or negedge rst_s) begin
    if (!rst_s) begin
      checksum <= '0;
    end else if (dl_start && (st == S_IDLE || st == S_RUN)) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + {8'h00, ioctl_dout};
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Scoreboard bench for rom_dl_ctrl: directed downloads, queued
// expected SDRAM requests checked by an independent monitor.
module tb_rom_dl_ctrl;

  typedef struct {
    logic [21:0] a;
    logic [15:0] d;
    logic [1:0]  ds;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        init_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        soft_reset = 1'b0;
  logic        ram_req;
  logic        ram_ack = 1'b0;
  logic [21:0] ram_addr;
  logic [15:0] ram_din;
  logic [1:0]  ram_ds;
  logic        ram_we;
  logic        rom_loaded;
  logic        core_reset;
  logic        overflow;
  logic [15:0] checksum;

  logic        ack_hold = 1'b0;
  exp_t        expq[$];
  int          total = 0;
  int          bad = 0;
  int          nreq = 0;

  rom_dl_ctrl dut (
    .clk_sys       (clk_sys),
    .init_n        (init_n),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .soft_reset    (soft_reset),
    .ram_req       (ram_req),
    .ram_ack       (ram_ack),
    .ram_addr      (ram_addr),
    .ram_din       (ram_din),
    .ram_ds        (ram_ds),
    .ram_we        (ram_we),
    .rom_loaded    (rom_loaded),
    .core_reset    (core_reset),
    .overflow      (overflow),
    .checksum      (checksum)
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM model: acknowledges one cycle after a request unless held.
  always @(posedge clk_sys or negedge init_n) begin
    if (!init_n)        ram_ack <= 1'b0;
    else if (!ack_hold) ram_ack <= ram_req;
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic expect_req(input logic [21:0] a, input logic [15:0] d,
                            input logic [1:0] ds);
    exp_t e;
    e.a = a;
    e.d = d;
    e.ds = ds;
    expq.push_back(e);
  endtask

  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!init_n) begin
        prev = 1'b0;
      end else if (ram_req !== prev) begin
        prev = ram_req;
        nreq++;
        if (expq.size() == 0) begin
          chk("unexpected_req", 32'(ram_addr), 32'hFFFF_FFFF);
        end else begin
          e = expq.pop_front();
          chk("req_addr", 32'(ram_addr), 32'(e.a));
          chk("req_din", 32'(ram_din), 32'(e.d));
          chk("req_ds", 32'(ram_ds), 32'(e.ds));
          chk("req_we", 32'(ram_we), 32'd1);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk_sys);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic end_dl();
    @(negedge clk_sys);
    ioctl_download = 1'b0;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    repeat (2) @(negedge clk_sys);
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic wait_run(input string nm);
    int n;
    n = 0;
    while (core_reset !== 1'b0 && n < 400) begin
      @(negedge clk_sys);
      n++;
    end
    chk({nm, "_run"}, 32'(core_reset), 32'd0);
  endtask

  task automatic reset_checks(input string nm);
    chk({nm, "_req"}, 32'(ram_req), 32'd0);
    chk({nm, "_addr"}, 32'(ram_addr), 32'd0);
    chk({nm, "_din"}, 32'(ram_din), 32'd0);
    chk({nm, "_ds"}, 32'(ram_ds), 32'd0);
    chk({nm, "_we"}, 32'(ram_we), 32'd1);
    chk({nm, "_core_rst"}, 32'(core_reset), 32'd1);
    chk({nm, "_loaded"}, 32'(rom_loaded), 32'd0);
    chk({nm, "_ovf"}, 32'(overflow), 32'd0);
    chk({nm, "_cksum"}, 32'(checksum), 32'd0);
  endtask

  initial begin : stim
    int base;
    int cnt;
    logic [15:0] ck_exp;
`ifdef ROM_DL_CHECKSUM_EN
    ck_exp = 16'h0101;
`else
    ck_exp = 16'h0000;
`endif

    repeat (3) @(negedge clk_sys);
    reset_checks("rst");
    init_n = 1'b1;
    repeat (3) @(negedge clk_sys);

    // Foreign slot index: nothing happens, core stays in reset.
    start_dl(8'd1);
    wr_byte(25'd0, 8'h11);
    wr_byte(25'd1, 8'h22);
    end_dl();
    repeat (20) @(negedge clk_sys);
    chk("idx1_nreq", 32'(nreq), 32'd0);
    chk("idx1_core_rst", 32'(core_reset), 32'd1);
    chk("idx1_loaded", 32'(rom_loaded), 32'd0);

    // One packed word, then exact hold length before RUN.
    start_dl(8'd0);
    expect_req(22'd0, 16'h2211, 2'b11);
    wr_byte(25'd0, 8'h11);
    wr_byte(25'd1, 8'h22);
    end_dl();
    repeat (18) @(posedge clk_sys);
    #1 chk("hold_still_rst", 32'(core_reset), 32'd1);
    @(posedge clk_sys);
    #1 chk("hold_run", 32'(core_reset), 32'd0);
    chk("run_loaded", 32'(rom_loaded), 32'd1);
    chk("run_we", 32'(ram_we), 32'd0);
    chk("run_addr", 32'(ram_addr), 32'h003F_FFFF);
    chk("w1_nreq", 32'(nreq), 32'd1);

    // Soft reset pulse in RUN.
    cnt = 0;
    @(negedge clk_sys);
    soft_reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys);
      soft_reset = 1'b0;
      if (core_reset) cnt++;
    end
    chk("soft_cycles", 32'(cnt), 32'd1);
    chk("soft_loaded", 32'(rom_loaded), 32'd1);

    // Pair, lone even byte, lone odd byte flushed at the end.
    base = nreq;
    start_dl(8'd0);
    chk("reload_core_rst", 32'(core_reset), 32'd1);
    chk("reload_we", 32'(ram_we), 32'd1);
    expect_req(22'd0, 16'hBBAA, 2'b11);
    expect_req(22'd1, 16'h3333, 2'b01);
    expect_req(22'd3, 16'h4444, 2'b10);
    wr_byte(25'd0, 8'hAA);
    wr_byte(25'd1, 8'hBB);
    wr_byte(25'd2, 8'h33);
    wr_byte(25'd7, 8'h44);
    end_dl();
    wait_run("mix");
    chk("mix_nreq", 32'(nreq - base), 32'd3);

    // Last in-range address pairs; ROM_LIMIT itself is dropped.
    base = nreq;
    start_dl(8'd0);
    expect_req(22'h00FFFF, 16'h02FF, 2'b11);
    wr_byte(25'h1FFFE, 8'hFF);
    wr_byte(25'h1FFFF, 8'h02);
    wr_byte(25'h20000, 8'h77);
    end_dl();
    wait_run("lim");
    chk("lim_nreq", 32'(nreq - base), 32'd1);
    chk("lim_cksum", 32'(checksum), 32'(ck_exp));

    // Ack stalled: one in flight plus four queued, sixth entry lost.
    base = nreq;
    start_dl(8'd0);
    expect_req(22'd0, 16'h0201, 2'b11);
    wr_byte(25'd0, 8'h01);
    wr_byte(25'd1, 8'h02);
    repeat (2) @(negedge clk_sys);
    ack_hold = 1'b1;
    expect_req(22'd1, 16'h0403, 2'b11);
    expect_req(22'd2, 16'h0605, 2'b11);
    expect_req(22'd3, 16'h0807, 2'b11);
    expect_req(22'd4, 16'h0A09, 2'b11);
    expect_req(22'd10, 16'h5A5A, 2'b01);
    for (int i = 2; i < 10; i++) wr_byte(25'(i), 8'(i + 1));
    wr_byte(25'd20, 8'h5A);
    wr_byte(25'd30, 8'h6B);
    chk("ovf_before_flush", 32'(overflow), 32'd0);
    end_dl();
    repeat (4) @(negedge clk_sys);
    chk("ovf_set", 32'(overflow), 32'd1);
    repeat (200) @(negedge clk_sys);
    ack_hold = 1'b0;
    wait_run("ovf");
    chk("ovf_nreq", 32'(nreq - base), 32'd6);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset while DRAIN waits on an ack, then a clean restart.
    start_dl(8'd0);
    ack_hold = 1'b1;
    expect_req(22'd0, 16'hC3C2, 2'b11);
    wr_byte(25'd0, 8'hC2);
    wr_byte(25'd1, 8'hC3);
    end_dl();
    repeat (5) @(negedge clk_sys);
    chk("drain_core_rst", 32'(core_reset), 32'd1);
    init_n = 1'b0;
    #1;
    reset_checks("mid");
    @(negedge clk_sys);
    ack_hold = 1'b0;
    init_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    base = nreq;
    start_dl(8'd0);
    expect_req(22'd2, 16'hD5D4, 2'b11);
    wr_byte(25'd4, 8'hD4);
    wr_byte(25'd5, 8'hD5);
    end_dl();
    wait_run("restart");
    chk("restart_nreq", 32'(nreq - base), 32'd1);
    chk("restart_loaded", 32'(rom_loaded), 32'd1);
    chk("restart_ovf", 32'(overflow), 32'd0);
    chk("exp_left", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
